lsu_mc: RTL and testbench

- Parametrised multi-cycle load/store unit for the RV core. Replaces the single-cycle combinational memory path.
- Takes one load/store request at a time from the execute stage and computes the effective address.
- Drives a ready/valid memory bus with byte strobes, and returns aligned, sign- or zero-extended load data to writeback.
- Adds misalignment detection, RV64 load/store support and a bus timeout.

---
 rtl/lsu_mc_if.sv | 30 +++
 rtl/lsu_mc.sv | 193 +++++++++++++++++++
 tb/tb_lsu_mc.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mc_if
// Purpose  : Memory-side ready/valid bus of the multi-cycle load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_mc_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic                mem_valid;
   logic                mem_ready;
   logic                mem_rw;
   logic [ADDR_W-1:0]   mem_addr;
   logic [XLEN-1:0]     mem_wdata;
   logic [XLEN/8-1:0]   mem_wstrb;
   logic                mem_rvalid;
   logic [XLEN-1:0]     mem_rdata;

   modport master (
      output mem_valid, mem_rw, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_rw, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/lsu_mc.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mc
// Purpose  : Multi-cycle load/store unit: address generation, legality
//            checks, byte-lane steering, load extension and bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mc #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  wire logic              clk,
   input  wire logic              nreset,
   input  wire logic              req_valid,
   output logic                   req_ready,
   input  wire logic              req_store,
   input  wire logic [2:0]        req_funct3,
   input  wire logic [XLEN-1:0]   req_base,
   input  wire logic [11:0]       req_imm,
   input  wire logic [XLEN-1:0]   req_wdata,
   input  wire logic [4:0]        req_rd,
   output logic                   rsp_valid,
   input  wire logic              rsp_ready,
   output logic [XLEN-1:0]        rsp_data,
   output logic [4:0]             rsp_rd,
   output logic                   rsp_store,
   output logic [1:0]             rsp_err,
   lsu_mc_if.master               bus
);
   localparam int c_NB    = XLEN / 8;
   localparam int c_OFF_W = $clog2(c_NB);
   localparam int c_CNT_W = $clog2(TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_TMAX = c_CNT_W'(TIMEOUT - 1);
   localparam logic [1:0] c_ERR_OK  = 2'b00;
   localparam logic [1:0] c_ERR_MIS = 2'b01;
   localparam logic [1:0] c_ERR_TO  = 2'b10;
   localparam logic [1:0] c_ERR_ILL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t               r_state;
   logic [c_OFF_W-1:0]   r_off;
   logic [2:0]           r_funct3;
   logic [c_CNT_W-1:0]   r_cnt;

   logic [ADDR_W-1:0]    w_ea;
   logic [c_OFF_W-1:0]   w_off;
   logic                 w_illegal;
   logic                 w_misal;
   logic [c_NB-1:0]      w_wstrb;
   logic [XLEN-1:0]      w_wdata;
   logic [XLEN-1:0]      w_shift;
   logic [XLEN-1:0]      w_load;

   assign w_ea  = req_base[ADDR_W-1:0] + ADDR_W'(signed'(req_imm));
   assign w_off = w_ea[c_OFF_W-1:0];

   // Unsigned variants are loads only; RV32 has neither D nor WU.
   assign w_illegal = (req_funct3 == 3'b111)
                   || ((XLEN == 32) && (req_funct3 == 3'b110 || req_funct3 == 3'b011))
                   || (req_store && req_funct3[2]);

   always_comb begin
      w_misal = 1'b0;
      w_wstrb = '1;
      w_wdata = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            w_wstrb = c_NB'(1) << w_off;
            w_wdata = {c_NB{req_wdata[7:0]}};
         end
         2'b01: begin
            w_misal = w_ea[0];
            w_wstrb = c_NB'(3) << w_off;
            w_wdata = {(c_NB/2){req_wdata[15:0]}};
         end
         2'b10: begin
            w_misal = |w_ea[1:0];
            w_wstrb = c_NB'(15) << w_off;
            w_wdata = {(c_NB/4){req_wdata[31:0]}};
         end
         default: begin
            w_misal = |w_ea[2:0];
         end
      endcase
   end

   always_comb begin
      w_shift = bus.mem_rdata >> {r_off, 3'b000};
      case (r_funct3)
         3'b000:  w_load = XLEN'(signed'(w_shift[7:0]));
         3'b001:  w_load = XLEN'(signed'(w_shift[15:0]));
         3'b010:  w_load = XLEN'(signed'(w_shift[31:0]));
         3'b100:  w_load = XLEN'(w_shift[7:0]);
         3'b101:  w_load = XLEN'(w_shift[15:0]);
         3'b110:  w_load = XLEN'(w_shift[31:0]);
         default: w_load = w_shift;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state       <= S_IDLE;
         r_off         <= '0;
         r_funct3      <= '0;
         r_cnt         <= '0;
         req_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_rd        <= '0;
         rsp_store     <= 1'b0;
         rsp_err       <= '0;
         bus.mem_valid <= 1'b0;
         bus.mem_rw    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wstrb <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  r_off     <= w_off;
                  r_funct3  <= req_funct3;
                  rsp_rd    <= req_rd;
                  rsp_store <= req_store;
                  rsp_data  <= '0;
                  if (w_illegal || w_misal) begin
                     rsp_err   <= w_illegal ? c_ERR_ILL : c_ERR_MIS;
                     rsp_valid <= 1'b1;
                     r_state   <= S_RESP;
                  end else begin
                     rsp_err       <= c_ERR_OK;
                     bus.mem_valid <= 1'b1;
                     bus.mem_rw    <= req_store;
                     bus.mem_addr  <= {w_ea[ADDR_W-1:c_OFF_W], c_OFF_W'(0)};
                     bus.mem_wdata <= req_store ? w_wdata : '0;
                     bus.mem_wstrb <= req_store ? w_wstrb : '0;
                     r_cnt         <= '0;
                     r_state       <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (bus.mem_ready) begin
                  bus.mem_valid <= 1'b0;
                  r_cnt         <= '0;
                  if (rsp_store) begin
                     rsp_valid <= 1'b1;
                     r_state   <= S_RESP;
                  end else begin
                     r_state   <= S_WAIT;
                  end
               end else if (r_cnt == c_TMAX) begin
                  bus.mem_valid <= 1'b0;
                  rsp_err       <= c_ERR_TO;
                  rsp_valid     <= 1'b1;
                  r_state       <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            S_WAIT: begin
               if (bus.mem_rvalid) begin
                  rsp_data  <= w_load;
                  rsp_valid <= 1'b1;
                  r_state   <= S_RESP;
               end else if (r_cnt == c_TMAX) begin
                  rsp_err   <= c_ERR_TO;
                  rsp_valid <= 1'b1;
                  r_state   <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            default: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_lsu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mc
// Purpose  : Drives an RV32 and an RV64 lsu_mc with identical requests and
//            checks both against a byte-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mc;
   typedef struct packed {
      logic [1:0]  err;
      logic [63:0] data;
      logic [63:0] addr;
      logic [7:0]  strb;
      logic [63:0] wd;
   } exp_t;

   logic        clk = 1'b0;
   logic        nreset;
   logic        req_valid, req_store, rsp_ready;
   logic [2:0]  req_funct3;
   logic [63:0] req_base, req_wdata;
   logic [11:0] req_imm;
   logic [4:0]  req_rd;

   logic        rr32, rv32, rs32, rr64, rv64, rs64;
   logic [31:0] rd32d;
   logic [63:0] rd64d;
   logic [4:0]  rt32, rt64;
   logic [1:0]  re32, re64;

   int n_chk = 0;
   int n_err = 0;
   int mode  = 0;

   // bus responder state, index 0 = RV32 DUT, 1 = RV64 DUT
   logic        rdy [2];
   logic        rvl [2];
   logic [63:0] rdat [2];
   logic [63:0] rd_exp [2];
   logic        pend [2];
   logic        rwq [2];
   int          dly [2];
   int          wcnt [2];

   logic        mv [2], mrw [2], rspv [2], rqr [2], rsps [2];
   logic [63:0] maddr [2], mwd [2], rspd [2];
   logic [7:0]  mstrb [2];
   logic [1:0]  rerr [2];
   logic [4:0]  rrd [2];

   lsu_mc_if #(.XLEN(32), .ADDR_W(32)) b32 ();
   lsu_mc_if #(.XLEN(64), .ADDR_W(64)) b64 ();

   lsu_mc #(.XLEN(32), .ADDR_W(32), .TIMEOUT(16)) u32 (
      .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(rr32),
      .req_store(req_store), .req_funct3(req_funct3), .req_base(req_base[31:0]),
      .req_imm(req_imm), .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
      .rsp_valid(rv32), .rsp_ready(rsp_ready), .rsp_data(rd32d), .rsp_rd(rt32),
      .rsp_store(rs32), .rsp_err(re32), .bus(b32.master)
   );

   lsu_mc #(.XLEN(64), .ADDR_W(64), .TIMEOUT(16)) u64 (
      .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(rr64),
      .req_store(req_store), .req_funct3(req_funct3), .req_base(req_base),
      .req_imm(req_imm), .req_wdata(req_wdata), .req_rd(req_rd),
      .rsp_valid(rv64), .rsp_ready(rsp_ready), .rsp_data(rd64d), .rsp_rd(rt64),
      .rsp_store(rs64), .rsp_err(re64), .bus(b64.master)
   );

   assign b32.mem_ready  = rdy[0];
   assign b32.mem_rvalid = rvl[0];
   assign b32.mem_rdata  = rdat[0][31:0];
   assign b64.mem_ready  = rdy[1];
   assign b64.mem_rvalid = rvl[1];
   assign b64.mem_rdata  = rdat[1];

   assign mv[0] = b32.mem_valid;   assign mv[1] = b64.mem_valid;
   assign mrw[0] = b32.mem_rw;     assign mrw[1] = b64.mem_rw;
   assign maddr[0] = {32'd0, b32.mem_addr};   assign maddr[1] = b64.mem_addr;
   assign mwd[0] = {32'd0, b32.mem_wdata};    assign mwd[1] = b64.mem_wdata;
   assign mstrb[0] = {4'd0, b32.mem_wstrb};   assign mstrb[1] = b64.mem_wstrb;
   assign rspv[0] = rv32;  assign rspv[1] = rv64;
   assign rqr[0] = rr32;   assign rqr[1] = rr64;
   assign rsps[0] = rs32;  assign rsps[1] = rs64;
   assign rspd[0] = {32'd0, rd32d};  assign rspd[1] = rd64d;
   assign rerr[0] = re32;  assign rerr[1] = re64;
   assign rrd[0] = rt32;   assign rrd[1] = rt64;

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode: 0 random bus, 1 never ready, 2 never returns data, 3 zero-wait
   initial begin
      for (int k = 0; k < 2; k++) begin
         rdy[k] = 1'b0; rvl[k] = 1'b0; rdat[k] = '0; pend[k] = 1'b0;
         rwq[k] = 1'b0; dly[k] = 0; wcnt[k] = 0; rd_exp[k] = '0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!nreset) begin
               rdy[k] = 1'b0; rvl[k] = 1'b0; pend[k] = 1'b0; wcnt[k] = 0;
            end else begin
               if (rdy[k] && !rwq[k] && mode != 2) begin
                  pend[k] = 1'b1;
                  dly[k]  = (mode == 3) ? 0 : int'($urandom_range(0, 2));
               end
               rvl[k] = 1'b0;
               if (pend[k]) begin
                  if (dly[k] == 0) begin
                     rvl[k] = 1'b1; rdat[k] = rd_exp[k]; pend[k] = 1'b0;
                  end else begin
                     dly[k]--;
                  end
               end else if (mv[k] && mode == 0 && $urandom_range(0, 3) == 0) begin
                  rvl[k] = 1'b1; rdat[k] = {$urandom, $urandom};
               end
               rwq[k] = mrw[k];
               if (!mv[k] || mode == 1) begin
                  rdy[k] = 1'b0; wcnt[k] = 0;
               end else if (mode == 3 || wcnt[k] >= 2 || $urandom_range(0, 1) == 1) begin
                  rdy[k] = 1'b1; wcnt[k] = 0;
               end else begin
                  rdy[k] = 1'b0; wcnt[k]++;
               end
            end
         end
      end
   end

   function automatic exp_t model(int xlen, bit st, logic [2:0] f3, logic [63:0] base,
                                  logic [11:0] imm, logic [63:0] wd, logic [63:0] rdv, int md);
      exp_t e;
      logic [63:0] ea, v, m;
      int size, nb, off, bits;
      bit ill;
      e    = '0;
      ea   = base + {{52{imm[11]}}, imm};
      if (xlen == 32) ea = ea & 64'hFFFF_FFFF;
      size = 1 << f3[1:0];
      nb   = xlen / 8;
      bits = 8 * size;
      ill  = (f3 == 3'd7) || (xlen == 32 && (f3 == 3'd6 || f3 == 3'd3)) || (st && f3[2]);
      if (ill) e.err = 2'd3;
      else if (ea % size != 0) e.err = 2'd1;
      else begin
         off    = int'(ea % nb);
         e.addr = ea - 64'(off);
         if (st) begin
            for (int i = 0; i < nb; i++) begin
               if (i >= off && i < off + size) e.strb[i] = 1'b1;
               e.wd[8*i +: 8] = wd[8*(i % size) +: 8];
            end
         end
         if (md == 1 || (md == 2 && !st)) e.err = 2'd2;
         else if (!st) begin
            v = rdv >> (8 * off);
            if (bits < 64) begin
               m = (64'd1 << bits) - 64'd1;
               v = v & m;
               if (!f3[2] && v[bits-1]) v = v | ~m;
            end
            if (xlen == 32) v = v & 64'hFFFF_FFFF;
            e.data = v;
         end
      end
      return e;
   endfunction

   task automatic wait_ready();
      bool_ok: begin
         for (int i = 0; i < 100; i++) begin
            if (rqr[0] && rqr[1]) disable bool_ok;
            @(negedge clk);
         end
         chk("req_ready_wait", {63'd0, rqr[0] & rqr[1]}, 64'd1);
      end
   endtask

   task automatic txn(bit st, logic [2:0] f3, logic [63:0] base, logic [11:0] imm,
                      logic [63:0] wd, logic [31:0] r32, logic [63:0] r64, int md, int hold);
      exp_t e [2];
      int vcnt [2];
      int lat [2];
      bit seen [2];
      int hc, elat;
      logic [4:0] tag;
      tag = 5'($urandom);
      wait_ready();
      mode = md;
      rd_exp[0] = {32'd0, r32};
      rd_exp[1] = r64;
      e[0] = model(32, st, f3, base, imm, wd, {32'd0, r32}, md);
      e[1] = model(64, st, f3, base, imm, wd, r64, md);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_base = base;
      req_imm = imm; req_wdata = wd; req_rd = tag; rsp_ready = (hold == 0);
      @(negedge clk);
      req_valid = 1'b0; req_store = $urandom_range(0, 1); req_funct3 = 3'($urandom);
      req_base = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      hc = 0;
      for (int k = 0; k < 2; k++) begin vcnt[k] = 0; lat[k] = 0; seen[k] = 1'b0; end
      for (int n = 1; n <= 80; n++) begin
         for (int k = 0; k < 2; k++) begin
            if (!seen[k] && mv[k]) begin
               vcnt[k]++;
               chk($sformatf("x%0d mem_addr", 32 + 32*k), maddr[k], e[k].addr);
               chk($sformatf("x%0d mem_rw", 32 + 32*k), {63'd0, mrw[k]}, {63'd0, st});
               chk($sformatf("x%0d mem_wstrb", 32 + 32*k), {56'd0, mstrb[k]}, {56'd0, e[k].strb});
               if (st) chk($sformatf("x%0d mem_wdata", 32 + 32*k), mwd[k], e[k].wd);
            end
            if (!seen[k] && rspv[k]) begin seen[k] = 1'b1; lat[k] = n; end
            if (seen[k] && !rsp_ready)
               chk($sformatf("x%0d rsp_hold_valid", 32 + 32*k), {63'd0, rspv[k]}, 64'd1);
            if (seen[k] && rspv[k]) begin
               chk($sformatf("x%0d rsp_err", 32 + 32*k), {62'd0, rerr[k]}, {62'd0, e[k].err});
               chk($sformatf("x%0d rsp_data", 32 + 32*k), rspd[k], e[k].data);
               chk($sformatf("x%0d rsp_rd", 32 + 32*k), {59'd0, rrd[k]}, {59'd0, tag});
               chk($sformatf("x%0d rsp_store", 32 + 32*k), {63'd0, rsps[k]}, {63'd0, st});
               chk($sformatf("x%0d req_ready_in_resp", 32 + 32*k), {63'd0, rqr[k]}, 64'd0);
            end
         end
         if (seen[0] && seen[1]) begin
            if (hc >= hold) break;
            hc++;
         end
         if (n == 80) chk("rsp_timeout", {62'd0, seen[1], seen[0]}, 64'd3);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (e[k].err == 2'd1 || e[k].err == 2'd3) begin
            chk($sformatf("x%0d no_bus_on_err", 32 + 32*k), 64'(vcnt[k]), 64'd0);
            chk($sformatf("x%0d err_latency", 32 + 32*k), 64'(lat[k]), 64'd1);
         end else if (md == 1) begin
            chk($sformatf("x%0d timeout_valid_cycles", 32 + 32*k), 64'(vcnt[k]), 64'd16);
         end else if (md == 3) begin
            elat = st ? 2 : 3;
            chk($sformatf("x%0d latency", 32 + 32*k), 64'(lat[k]), 64'(elat));
            chk($sformatf("x%0d valid_cycles", 32 + 32*k), 64'(vcnt[k]), 64'd1);
         end
      end
   endtask

   task automatic chk_reset_outputs(string tag);
      chk({tag, " x32 outputs"}, {63'd0, |{rr32, rv32, rd32d, rt32, rs32, re32, b32.mem_valid,
          b32.mem_rw, b32.mem_addr, b32.mem_wdata, b32.mem_wstrb}}, 64'd0);
      chk({tag, " x64 outputs"}, {63'd0, |{rr64, rv64, rd64d, rt64, rs64, re64, b64.mem_valid,
          b64.mem_rw, b64.mem_addr, b64.mem_wdata, b64.mem_wstrb}}, 64'd0);
   endtask

   initial begin
      bit          st;
      logic [2:0]  f3;
      logic [11:0] imm;
      logic [63:0] base;
      int          r, md, hold;

      nreset = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
      req_base = '0; req_imm = '0; req_wdata = '0; req_rd = '0; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      nreset = 1'b1;
      @(negedge clk);
      chk("x32 req_ready_after_reset", {63'd0, rr32}, 64'd1);
      chk("x64 req_ready_after_reset", {63'd0, rr64}, 64'd1);

      txn(0, 3'b010, 64'h100, 12'h004, 64'h0, 32'h8000_00F0, {32'h8000_00F0, 32'h0}, 3, 0);
      txn(0, 3'b000, 64'h103, 12'h000, 64'h0, 32'h8F00_0000, {32'h0, 32'h8F00_0000}, 3, 0);
      txn(0, 3'b100, 64'h103, 12'h000, 64'h0, 32'h8F00_0000, {32'h0, 32'h8F00_0000}, 3, 0);
      txn(1, 3'b001, 64'h200, 12'hFFE, 64'h1234_ABCD, 32'h0, 64'h0, 3, 0);
      txn(0, 3'b010, 64'h102, 12'h000, 64'h0, 32'h1, 64'h1, 3, 0);
      txn(0, 3'b011, 64'h108, 12'h000, 64'h0, 32'h5, 64'hFEDC_BA98_7654_3210, 3, 0);
      txn(0, 3'b010, 64'h100, 12'h000, 64'h0, 32'h1, 64'h1, 1, 0);
      txn(0, 3'b010, 64'h104, 12'h000, 64'h0, 32'h7654_3210, {32'h7654_3210, 32'h0}, 0, 0);
      txn(0, 3'b110, 64'h00C, 12'h000, 64'h0, 32'h8000_0001, {32'h8000_0001, 32'h1234_5678}, 0, 0);
      txn(1, 3'b011, 64'h008, 12'h000, 64'h0102_0304_0506_0708, 32'h0, 64'h0, 3, 0);
      txn(0, 3'b010, 64'h010, 12'h000, 64'h0, 32'hCAFE_F00D, {32'h0, 32'hCAFE_F00D}, 0, 5);
      txn(0, 3'b000, 64'h0, 12'hFFF, 64'h0, 32'h8100_0000, 64'h8100_0000_0000_0000, 0, 0);
      txn(0, 3'b001, 64'h20, 12'h000, 64'h0, 32'h1, 64'h1, 2, 0);
      txn(1, 3'b110, 64'h20, 12'h000, 64'h0, 32'h1, 64'h1, 0, 0);
      txn(1, 3'b111, 64'h20, 12'h000, 64'h0, 32'h1, 64'h1, 0, 0);

      for (int i = 0; i < 200; i++) begin
         st   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         base = {$urandom, $urandom & 32'hFFFF_FFF8};
         r    = int'($urandom_range(0, 3));
         imm  = (r == 0) ? 12'($urandom) : (r == 1) ? 12'd0 : 12'($urandom_range(0, 15));
         r    = int'($urandom_range(0, 9));
         md   = (r < 6) ? 0 : (r < 8) ? 3 : (r == 8) ? 1 : 2;
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         txn(st, f3, base, imm, {$urandom, $urandom}, $urandom, {$urandom, $urandom}, md, hold);
      end

      // reset while both units sit in WAIT with no data coming back
      wait_ready();
      mode = 2;
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
      req_base = 64'h40; req_imm = 12'h0; req_rd = 5'd7;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("in_wait x32", {62'd0, b32.mem_valid, rv32}, 64'd0);
      chk("in_wait x64", {62'd0, b64.mem_valid, rv64}, 64'd0);
      nreset = 1'b0;
      #1;
      chk_reset_outputs("mid_wait_reset");
      @(negedge clk);
      mode = 0;
      nreset = 1'b1;
      @(negedge clk);
      chk("x32 req_ready_after_mid_reset", {63'd0, rr32}, 64'd1);
      chk("x64 req_ready_after_mid_reset", {63'd0, rr64}, 64'd1);
      txn(0, 3'b010, 64'h100, 12'h004, 64'h0, 32'h8000_00F0, {32'h8000_00F0, 32'h0}, 3, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
`default_nettype wire
